// File: rtl/gpu_pkg.sv
// Shared core definitions: scheduler state encodings and special-register layout.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    // Special registers sit at the top of each bank; offsets count down from NUM_REGS.
    localparam int SPR_BLOCK_ID   = 3;
    localparam int SPR_THREAD_ID  = 2;
    localparam int SPR_THREADS_PB = 1;

    // Absolute register index of a special register in a bank of num_regs entries.
    function automatic int spr_index(input int num_regs, input int offset);
        return num_regs - offset;
    endfunction

endpackage

// File: rtl/simt_register_file_if.sv
// Scheduler/ALU/LSU-facing bundle of the SIMT register file.
interface simt_register_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LANES  = 4,
    parameter int ID_W   = 4
);
    logic [2:0]              core_state;
    logic [LANES-1:0]        lane_enable;
    logic [ID_W-1:0]         block_id;
    logic [ID_W-1:0]         threads_per_block;
    logic [ADDR_W-1:0]       rs_addr;
    logic [ADDR_W-1:0]       rt_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    alu_we;
    logic [LANES*DATA_W-1:0] alu_wdata;
    logic [LANES-1:0]        lsu_issue;
    logic [LANES-1:0]        lsu_wb_valid;
    logic [LANES*ADDR_W-1:0] lsu_wb_addr;
    logic [LANES*DATA_W-1:0] lsu_wb_data;
    logic [LANES*DATA_W-1:0] rs_data;
    logic [LANES*DATA_W-1:0] rt_data;
    logic [LANES-1:0]        hazard;
    logic                    stall;

    modport master (
        output core_state, lane_enable, block_id, threads_per_block,
               rs_addr, rt_addr, rd_addr, alu_we, alu_wdata,
               lsu_issue, lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  rs_data, rt_data, hazard, stall
    );

    modport slave (
        input  core_state, lane_enable, block_id, threads_per_block,
               rs_addr, rt_addr, rd_addr, alu_we, alu_wdata,
               lsu_issue, lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output rs_data, rt_data, hazard, stall
    );
endinterface

// File: rtl/regfile_bank.sv
// One lane's register bank: two async read ports, ALU and LSU write ports
// (LSU wins on collision), special-register load and pending-load scoreboard.
module regfile_bank
    import gpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ID_W    = 4,
    parameter int LANE_ID = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spr_load,
    input  logic [ID_W-1:0]   block_id,
    input  logic [ID_W-1:0]   threads_per_block,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              alu_we,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              lsu_issue,
    input  logic              lsu_wb_valid,
    input  logic [ADDR_W-1:0] lsu_wb_addr,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              hazard
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_BID = ADDR_W'(spr_index(NUM_REGS, SPR_BLOCK_ID));
    localparam logic [ADDR_W-1:0] ADDR_TID = ADDR_W'(spr_index(NUM_REGS, SPR_THREAD_ID));
    localparam logic [ADDR_W-1:0] ADDR_TPB = ADDR_W'(spr_index(NUM_REGS, SPR_THREADS_PB));

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // Special registers occupy the top three indices and are read-only.
    function automatic logic is_spr(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_BID;
    endfunction

    // Scoreboard update: clear for the returning load, then set for the new issue.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments; the default first keeps it latch-free.
        pending_next = pending;
        if (lsu_wb_valid) pending_next[lsu_wb_addr] = 1'b0;
        if (lsu_issue && !is_spr(rd_addr)) pending_next[rd_addr] = 1'b1;
    end

    // Register and scoreboard state; later statements take priority on the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every storage entry is reset here, so this array maps to flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            // NOTE: non-blocking assignments; the last one to an entry in this block wins, giving LSU priority.
            pending <= pending_next;
            if (alu_we && !is_spr(rd_addr)) regs[rd_addr] <= alu_wdata;
            if (lsu_wb_valid && !is_spr(lsu_wb_addr)) regs[lsu_wb_addr] <= lsu_wb_data;
            if (spr_load) begin
                regs[ADDR_BID] <= DATA_W'(block_id);
                regs[ADDR_TID] <= DATA_W'(LANE_ID);
                regs[ADDR_TPB] <= DATA_W'(threads_per_block);
            end
        end
    end

    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];
    assign hazard  = pending[rs_addr] | pending[rt_addr] | pending[rd_addr];

endmodule

// File: rtl/simt_register_file.sv
// Banked SIMT register file: one regfile_bank per lane, stall from enabled-lane hazards.
module simt_register_file
    import gpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LANES  = 4,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    simt_register_file_if.slave bus
);
    logic                    in_request;
    logic                    stall;
    logic [LANES-1:0]        hazard;
    logic [LANES*DATA_W-1:0] rs_data;
    logic [LANES*DATA_W-1:0] rt_data;

    assign in_request = (bus.core_state == CORE_REQUEST);
    assign stall      = |(hazard & bus.lane_enable);

    for (genvar t = 0; t < LANES; t++) begin : g_lane
        regfile_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .ID_W   (ID_W),
            .LANE_ID(t)
        ) u_bank (
            .clk              (clk),
            .reset            (reset),
            .spr_load         (in_request && bus.lane_enable[t]),
            .block_id         (bus.block_id),
            .threads_per_block(bus.threads_per_block),
            .rs_addr          (bus.rs_addr),
            .rt_addr          (bus.rt_addr),
            .rd_addr          (bus.rd_addr),
            .alu_we           (bus.alu_we && bus.lane_enable[t] && in_request && !stall),
            .alu_wdata        (bus.alu_wdata[t*DATA_W +: DATA_W]),
            .lsu_issue        (bus.lsu_issue[t]),
            .lsu_wb_valid     (bus.lsu_wb_valid[t]),
            .lsu_wb_addr      (bus.lsu_wb_addr[t*ADDR_W +: ADDR_W]),
            .lsu_wb_data      (bus.lsu_wb_data[t*DATA_W +: DATA_W]),
            .rs_data          (rs_data[t*DATA_W +: DATA_W]),
            .rt_data          (rt_data[t*DATA_W +: DATA_W]),
            .hazard           (hazard[t])
        );
    end

    assign bus.rs_data = rs_data;
    assign bus.rt_data = rt_data;
    assign bus.hazard  = hazard;
    assign bus.stall   = stall;

endmodule

// File: tb/tb_simt_register_file.sv
// Bench for simt_register_file: per-cycle vectors with expected read/hazard outputs.
module tb_simt_register_file;
    import gpu_pkg::*;

    localparam logic [2:0] IDL = CORE_IDLE;
    localparam logic [2:0] REQ = CORE_REQUEST;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    simt_register_file_if #(.DATA_W(8), .ADDR_W(4), .LANES(4), .ID_W(4)) bus ();

    simt_register_file #(.DATA_W(8), .ADDR_W(4), .LANES(4), .ID_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  cs;
        logic [3:0]  en;
        logic [3:0]  rs, rt, rd;
        logic        alu_we;
        logic [31:0] alu_wd;
        logic [3:0]  issue, wbv;
        logic [15:0] wba;
        logic [31:0] wbd;
        logic [31:0] exp_rs, exp_rt;
        logic [3:0]  exp_hz;
        logic        exp_st;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rs, rt;
        logic [3:0]  hz;
        logic        st;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(
        input logic rst, input logic [2:0] cs, input logic [3:0] en,
        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
        input logic alu_we, input logic [31:0] alu_wd,
        input logic [3:0] issue, input logic [3:0] wbv,
        input logic [15:0] wba, input logic [31:0] wbd,
        input logic [31:0] exp_rs, input logic [31:0] exp_rt,
        input logic [3:0] exp_hz, input logic exp_st);
        vec_t r;
        r.rst = rst; r.cs = cs; r.en = en; r.rs = rs; r.rt = rt; r.rd = rd;
        r.alu_we = alu_we; r.alu_wd = alu_wd; r.issue = issue; r.wbv = wbv;
        r.wba = wba; r.wbd = wbd; r.exp_rs = exp_rs; r.exp_rt = exp_rt;
        r.exp_hz = exp_hz; r.exp_st = exp_st;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check($sformatf("row%0d.rs_data", e.idx), bus.rs_data, e.rs);
        check($sformatf("row%0d.rt_data", e.idx), bus.rt_data, e.rt);
        check($sformatf("row%0d.hazard", e.idx), 32'(bus.hazard), 32'(e.hz));
        check($sformatf("row%0d.stall", e.idx), 32'(bus.stall), 32'(e.st));
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then let the edge commit.
    task automatic apply(input vec_t r, input int idx);
        exp_t e;
        reset                 = r.rst;
        bus.core_state        = r.cs;
        bus.lane_enable       = r.en;
        bus.rs_addr           = r.rs;
        bus.rt_addr           = r.rt;
        bus.rd_addr           = r.rd;
        bus.alu_we            = r.alu_we;
        bus.alu_wdata         = r.alu_wd;
        bus.lsu_issue         = r.issue;
        bus.lsu_wb_valid      = r.wbv;
        bus.lsu_wb_addr       = r.wba;
        bus.lsu_wb_data       = r.wbd;
        e.idx = idx; e.rs = r.exp_rs; e.rt = r.exp_rt; e.hz = r.exp_hz; e.st = r.exp_st;
        sb.push_back(e);
        @(negedge clk);
        compare_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset                 = 1'b1;
        bus.block_id          = 4'd3;
        bus.threads_per_block = 4'd4;
        apply(mk(1, IDL, 4'h0, 4'd0, 4'd0, 4'd0, 0, 32'h0, 4'h0, 4'h0, 16'h0, 32'h0,
                 32'hx, 32'hx, 4'hx, 1'bx), -1);
        sb.delete();
        n_checks = 0;
        n_pass   = 0;

        //              rst cs   en    rs     rt     rd    we wdata          iss   wbv   wba       wbd            exp_rs         exp_rt         hz    st
        tbl.push_back(mk(0, IDL, 4'hF, 4'd13, 4'd15, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, REQ, 4'hF, 4'd13, 4'd14, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd14, 4'd15, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h03020100,  32'h04040404,  4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd13, 4'd0,  4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h03030303,  32'h0,         4'h0, 0));
        // ALU write to R5 with only lane 0 enabled; same-cycle read sees old data.
        tbl.push_back(mk(0, REQ, 4'h1, 4'd5,  4'd5,  4'd5, 1, 32'h99773CA5,  4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd5,  4'd13, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h000000A5,  32'h03030303,  4'h0, 0));
        // Load to R7 on lane 0, RAW hazard stalls and blocks the ALU write to R8.
        tbl.push_back(mk(0, IDL, 4'hF, 4'd0,  4'd0,  4'd7, 0, 32'h0,         4'h1, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, REQ, 4'hF, 4'd7,  4'd0,  4'd8, 1, 32'h11111111,  4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h1, 1));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd8,  4'd7,  4'd0, 0, 32'h0,         4'h0, 4'h1, 16'h0007, 32'h00000042,  32'h0,         32'h0,         4'h1, 1));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd7,  4'd8,  4'd7, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h00000042,  32'h0,         4'h0, 0));
        // Lane 1 ALU/LSU collision on R4 (LSU wins), then split R4/R6.
        tbl.push_back(mk(0, REQ, 4'h2, 4'd4,  4'd6,  4'd4, 1, 32'h00001100,  4'h0, 4'h2, 16'h0040, 32'h00002200,  32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd4,  4'd6,  4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h00002200,  32'h0,         4'h0, 0));
        tbl.push_back(mk(0, REQ, 4'h2, 4'd4,  4'd6,  4'd4, 1, 32'h00001100,  4'h0, 4'h2, 16'h0060, 32'h00002200,  32'h00002200,  32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd4,  4'd6,  4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h00001100,  32'h00002200,  4'h0, 0));
        // Lane 2: issue R9, then issue+writeback R9 together keeps it pending.
        tbl.push_back(mk(0, IDL, 4'hF, 4'd0,  4'd0,  4'd9, 0, 32'h0,         4'h4, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd9,  4'd0,  4'd9, 0, 32'h0,         4'h4, 4'h4, 16'h0900, 32'h005A0000,  32'h0,         32'h0,         4'h4, 1));
        tbl.push_back(mk(0, IDL, 4'hB, 4'd9,  4'd0,  4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h005A0000,  32'h0,         4'h4, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd0,  4'd9,  4'd0, 0, 32'h0,         4'h0, 4'h4, 16'h0900, 32'h005B0000,  32'h0,         32'h005A0000,  4'h4, 1));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd9,  4'd0,  4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h005B0000,  32'h0,         4'h0, 0));
        // Writes and load issue aimed at special registers are dropped.
        tbl.push_back(mk(0, REQ, 4'hF, 4'd14, 4'd15, 4'd14, 1, 32'hFFFFFFFF, 4'h1, 4'h0, 16'h0,    32'h0,         32'h03020100,  32'h04040404,  4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd14, 4'd15, 4'd14, 0, 32'h0,        4'h0, 4'h0, 16'h0,    32'h0,         32'h03020100,  32'h04040404,  4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd10, 4'd15, 4'd10, 1, 32'h12345678, 4'h0, 4'h8, 16'hF000, 32'hEE000000,  32'h0,         32'h04040404,  4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd10, 4'd15, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h04040404,  4'h0, 0));
        // ALU writes only take effect in CORE_REQUEST.
        tbl.push_back(mk(0, REQ, 4'hF, 4'd10, 4'd0,  4'd10, 1, 32'h12345678, 4'h0, 4'h0, 16'h0,    32'h0,         32'h0,         32'h0,         4'h0, 0));
        tbl.push_back(mk(0, IDL, 4'hF, 4'd10, 4'd13, 4'd0, 0, 32'h0,         4'h0, 4'h0, 16'h0,    32'h0,         32'h12345678,  32'h03030303,  4'h0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while a lane 3 load to R3 is outstanding; the late writeback still lands.
        apply(mk(0, IDL, 4'hF, 4'd0, 4'd0,  4'd3, 0, 32'h0, 4'h8, 4'h0, 16'h0,    32'h0,        32'h0,        32'h0, 4'h0, 0), 100);
        apply(mk(1, IDL, 4'hF, 4'd3, 4'd0,  4'd0, 0, 32'h0, 4'h0, 4'h0, 16'h0,    32'h0,        32'h0,        32'h0, 4'h8, 1), 101);
        apply(mk(0, IDL, 4'hF, 4'd3, 4'd14, 4'd0, 0, 32'h0, 4'h0, 4'h8, 16'h3000, 32'h77000000, 32'h0,        32'h0, 4'h0, 0), 102);
        apply(mk(0, IDL, 4'hF, 4'd3, 4'd0,  4'd3, 0, 32'h0, 4'h0, 4'h0, 16'h0,    32'h0,        32'h77000000, 32'h0, 4'h0, 0), 103);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simt_register_file.md
Name: simt_register_file

Overview:
- Banked register file holding one private register bank per SIMT lane of a compute core.
- Supports parametrised data width, register count and lane count.
- Provides a second write port for asynchronous LSU load writeback, plus a per-register pending-load scoreboard that raises a stall on RAW/WAW hazards.
- Sits between the core scheduler/decoder, the per-lane ALUs and the per-lane LSUs; replaces the single-lane 8-bit register file.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.
- LANES, 4, number of threads/lanes (banks).
- ID_W, 4, width of block_id / threads_per_block inputs.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- core_state  in  3  scheduler state; writes and special-register loads occur only in CORE_REQUEST.
- lane_enable  in  LANES  per-lane active mask.
- block_id  in  ID_W  current block index.
- threads_per_block  in  ID_W  block size.
- rs_addr, rt_addr, rd_addr  in  ADDR_W  decoded operand addresses, shared by all lanes.
- alu_we  in  1  ALU write request.
- alu_wdata  in  LANES*DATA_W  per-lane ALU result; lane t is at [t*DATA_W +: DATA_W].
- lsu_issue  in  LANES  per-lane load issued this cycle, destination rd_addr.
- lsu_wb_valid  in  LANES  per-lane load data returning.
- lsu_wb_addr  in  LANES*ADDR_W  per-lane load destination.
- lsu_wb_data  in  LANES*DATA_W  per-lane load data.
- rs_data, rt_data  out  LANES*DATA_W  per-lane combinational read data.
- hazard  out  LANES  per-lane pending[rs]|pending[rt]|pending[rd].
- stall  out  1  OR of (hazard & lane_enable).

Behaviour:
- Reset (synchronous): all registers of all banks are 0, all pending bits are 0. Consequently rs_data, rt_data, hazard and stall all read 0 in the cycle after reset.
- Reads: asynchronous, no bypass. A read returns the value held before the current clock edge.
- Special registers: R[NUM_REGS-3] = block_id, R[NUM_REGS-2] = lane index t, R[NUM_REGS-1] = threads_per_block.
  - All three are zero-extended to DATA_W.
  - They are loaded every cycle where core_state == CORE_REQUEST and lane_enable[t] is set.
  - They are read-only: ALU or LSU writes addressed to them are silently dropped.
- ALU write port: bank t is written at rd_addr with alu_wdata[t] when alu_we && lane_enable[t] && core_state == CORE_REQUEST && !stall.
- LSU write port: bank t is written at lsu_wb_addr[t] when lsu_wb_valid[t]. This is independent of core_state, lane_enable and stall.
- Same-cycle ALU and LSU write to the same register of the same lane: the LSU data wins. The two ports may write different registers of one bank in the same cycle.
- Scoreboard, per lane, NUM_REGS bits:
  - lsu_issue[t] sets pending[t][rd_addr].
  - lsu_wb_valid[t] clears pending[t][lsu_wb_addr[t]].
  - Set and clear of the same bit in one cycle: set wins, because the clear belongs to an older load.
  - lsu_issue to a special register is ignored.
- Hazard and stall are combinational from current pending bits and current addresses; there is no extra latency.
- Write latency is 1 cycle: data written at edge N is visible on the read ports after edge N.
- Reset asserted mid-load clears pending. A later lsu_wb_valid still writes its data, and its clear becomes a no-op.
- Disabled lanes (lane_enable[t] = 0) still accept LSU writebacks and scoreboard updates, but never contribute to stall.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state encodings, with CORE_REQUEST = 3'b011.
  - Special-register offset constants SPR_BLOCK_ID, SPR_THREAD_ID and SPR_THREADS_PB, expressed relative to NUM_REGS.
- One sub-module, regfile_bank: a single-lane bank with 2 read ports, 2 write ports, LSU priority, special-register load and the pending bitvector. simt_register_file generates LANES instances and ORs the lane hazards into stall.

Test Plan:
- Reset, then CORE_REQUEST with block_id = 3, threads_per_block = 4 and all lanes enabled -> lane 2 reads R13 = 3, R14 = 2, R15 = 4; R0 reads 0.
- ALU write rd = 5, alu_wdata lane0 = 8'hA5, lane1 = 8'h3C, lane_enable = 4'b0001 -> after 1 edge, lane0 R5 = 8'hA5 and lane1 R5 = 0. A same-cycle read of R5 returns the old value.
- lsu_issue lane0 with rd = 7, next cycle rs = 7 -> hazard[0] = 1 and stall = 1, and the ALU write is blocked. Then lsu_wb lane0 to addr 7 with data 8'h42 -> pending cleared, stall = 0, R7 = 8'h42.
- Same cycle: ALU write R4 = 8'h11 and LSU writeback R4 = 8'h22 on lane1 -> R4 = 8'h22. Same cycle with LSU to R6 instead -> R4 = 8'h11 and R6 = 8'h22.
- lsu_issue and lsu_wb_valid to R9 in the same cycle -> pending[9] remains 1. An ALU write to R14 = 8'hFF -> R14 stays equal to the lane index.
- Issue a load to R3, assert reset, then deliver lsu_wb data 8'h77 -> after reset pending = 0, stall = 0, and R3 = 8'h77 after the writeback.
